// File: rtl/aes_block_serializer.sv
// Purpose: unload one 128-bit AES block as 16 bytes, most significant byte first.
// Latency: first byte valid the cycle after the input handshake; one idle cycle between blocks (17-cycle minimum period).
// Backpressure: out_ready low holds out_byte/out_last/idx stable indefinitely; in_ready is low for the whole block.
module aes_block_serializer #(
  parameter int NBYTES = 16,
  parameter int BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W*NBYTES-1:0] in_block,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BYTE_W-1:0]        out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam int BLK_W = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] buffer;
  logic [BLK_W-1:0] shifted;

  // Capture a block in IDLE, then step the byte index on every accepted byte until the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      buffer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer <= in_block;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Select the current byte from the held buffer; zero while idle so the bus is quiet between blocks.
  always_comb begin
    shifted  = buffer << (BYTE_W * idx);
    out_byte = (state == SEND) ? shifted[BLK_W-1 -: BYTE_W] : '0;
  end

  // Handshake and status flags decode purely from registered state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SEND);
    out_valid = (state == SEND);
    out_last  = (state == SEND) && (idx == LAST_IDX);
  end

endmodule
